// File: rtl/viterbi_pkg.sv
// Shared trellis constants, scheduler state encoding and the branch-label helper
// for the K=7, rate-1/2 (171o/133o) LRPT Viterbi decoder.
package viterbi_pkg;

    localparam int K          = 7;
    localparam int NUM_STATES = 64;

    localparam logic [K-1:0] G1 = 7'b1111001;
    localparam logic [K-1:0] G2 = 7'b1011011;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

    // Encoder output pair {e0, e1} for input bit b leaving predecessor prev.
    function automatic logic [1:0] expected_bits(input logic [5:0] prev, input logic b);
        logic [K-1:0] shift_reg;
        shift_reg = {b, prev};
        return {^(G1 & shift_reg), ^(G2 & shift_reg)};
    endfunction

endpackage

// File: rtl/viterbi_bm_unit.sv
// Branch metrics for the four possible encoder output pairs of one soft symbol pair.
// Output bmXY is the distance to the pair (e0=X, e1=Y).
module viterbi_bm_unit #(
    parameter int SOFT_WIDTH = 8
) (
    input  logic [SOFT_WIDTH-1:0] y0,
    input  logic [SOFT_WIDTH-1:0] y1,
    output logic [SOFT_WIDTH:0]   bm00,
    output logic [SOFT_WIDTH:0]   bm01,
    output logic [SOFT_WIDTH:0]   bm10,
    output logic [SOFT_WIDTH:0]   bm11
);

    localparam logic [SOFT_WIDTH-1:0] SOFT_MAX = '1;

    logic [SOFT_WIDTH:0] dist0_zero, dist0_one;
    logic [SOFT_WIDTH:0] dist1_zero, dist1_one;

    assign dist0_zero = {1'b0, y0};
    assign dist0_one  = {1'b0, SOFT_MAX - y0};
    assign dist1_zero = {1'b0, y1};
    assign dist1_one  = {1'b0, SOFT_MAX - y1};

    assign bm00 = dist0_zero + dist1_zero;
    assign bm01 = dist0_zero + dist1_one;
    assign bm10 = dist0_one  + dist1_zero;
    assign bm11 = dist0_one  + dist1_one;

endmodule

// File: rtl/viterbi_acs_scheduler.sv
// Sequences an external ACS bank over all 64 trellis states per soft pair, keeping a
// ping-pong metric store with per-symbol normalisation and emitting a decision word.
module viterbi_acs_scheduler
    import viterbi_pkg::*;
#(
    parameter int NUM_ACS         = 8,
    parameter int STATE_MET_WIDTH = 20,
    parameter int SOFT_WIDTH      = 8,
    parameter int ACS_LATENCY     = 1,
    parameter int INIT_MET        = 1024
) (
    input  logic                               clk,
    input  logic                               sys_rst,
    input  logic                               sym_valid,
    output logic                               sym_ready,
    input  logic [SOFT_WIDTH-1:0]              sym_y0,
    input  logic [SOFT_WIDTH-1:0]              sym_y1,
    input  logic                               restart,
    output logic                               acs_valid,
    output logic [NUM_ACS*STATE_MET_WIDTH-1:0] acs_sm0,
    output logic [NUM_ACS*STATE_MET_WIDTH-1:0] acs_sm1,
    output logic [NUM_ACS*STATE_MET_WIDTH-1:0] acs_bm0,
    output logic [NUM_ACS*STATE_MET_WIDTH-1:0] acs_bm1,
    input  logic                               acs_valid_out,
    input  logic [NUM_ACS*STATE_MET_WIDTH-1:0] acs_sm_out,
    input  logic [NUM_ACS*6-1:0]               acs_prev_state,
    output logic                               dec_valid,
    input  logic                               dec_ready,
    output logic [63:0]                        dec_word,
    output logic [STATE_MET_WIDTH-1:0]         norm_min
);

    localparam int W           = STATE_MET_WIDTH;
    localparam int BM_W        = SOFT_WIDTH + 1;
    localparam int NUM_BATCHES = NUM_STATES / NUM_ACS;
    localparam int CNT_W       = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam logic [CNT_W-1:0] LAST_BATCH = CNT_W'(NUM_BATCHES - 1);

    if ((NUM_STATES % NUM_ACS) != 0 || ACS_LATENCY < 1 || W <= BM_W) begin : g_param_check
        $error("viterbi_acs_scheduler: unsupported parameter combination");
    end

    sched_state_t state, state_next;

    logic                  active;
    logic                  inactive;
    logic [W-1:0]          met [2][NUM_STATES];
    logic [W-1:0]          offset;
    logic [W-1:0]          run_min;
    logic [W-1:0]          beat_min;
    logic [W-1:0]          new_min;
    logic [SOFT_WIDTH-1:0] y0_q, y1_q;
    logic [CNT_W-1:0]      batch;
    logic [CNT_W-1:0]      wcnt;
    logic                  accept;
    logic                  beat;
    logic                  last_beat;
    logic [BM_W-1:0]       bm00, bm01, bm10, bm11;
    logic [4*BM_W-1:0]     bm_all;

    assign inactive  = ~active;
    assign accept    = (state == IDLE) && !restart && sym_valid;
    assign beat      = acs_valid_out && (state == ISSUE || state == DRAIN);
    assign last_beat = beat && (wcnt == LAST_BATCH);

    viterbi_bm_unit #(
        .SOFT_WIDTH(SOFT_WIDTH)
    ) u_bm (
        .y0  (y0_q),
        .y1  (y1_q),
        .bm00(bm00),
        .bm01(bm01),
        .bm10(bm10),
        .bm11(bm11)
    );

    assign bm_all = {bm11, bm10, bm01, bm00};

    function automatic logic [W-1:0] pick_bm(input logic [1:0] e, input logic [4*BM_W-1:0] bms);
        return W'(bms[int'(e)*BM_W +: BM_W]);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)                state_next = ISSUE;
            ISSUE:   if (batch == LAST_BATCH)   state_next = DRAIN;
            DRAIN:   if (last_beat)             state_next = DONE;
            DONE:    if (dec_ready)             state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // NOTE: every output gets a default before any branch so no latch can be inferred.
    always_comb begin
        logic [5:0] st, p0, p1;
        st        = '0;
        p0        = '0;
        p1        = '0;
        sym_ready = (state == IDLE) && !restart;
        dec_valid = (state == DONE);
        acs_valid = 1'b0;
        acs_sm0   = '0;
        acs_sm1   = '0;
        acs_bm0   = '0;
        acs_bm1   = '0;
        if (state == ISSUE) begin
            acs_valid = 1'b1;
            for (int i = 0; i < NUM_ACS; i++) begin
                st = 6'(int'(batch) * NUM_ACS + i);
                p0 = {1'b0, st[5:1]};
                p1 = {1'b1, st[5:1]};
                acs_sm0[i*W +: W] = met[active][p0] - offset;
                acs_sm1[i*W +: W] = met[active][p1] - offset;
                acs_bm0[i*W +: W] = pick_bm(expected_bits(p0, st[0]), bm_all);
                acs_bm1[i*W +: W] = pick_bm(expected_bits(p1, st[0]), bm_all);
            end
        end
    end

    // Running minimum over the beat, folded with earlier beats of the same symbol.
    always_comb begin
        beat_min = acs_sm_out[W-1:0];
        for (int i = 1; i < NUM_ACS; i++) begin
            if (acs_sm_out[i*W +: W] < beat_min) beat_min = acs_sm_out[i*W +: W];
        end
        new_min = beat_min;
        if (wcnt != '0 && run_min < beat_min) new_min = run_min;
    end

    // NOTE: the metric banks are reset explicitly because decoding starts from known metrics.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            active   <= 1'b0;
            offset   <= '0;
            run_min  <= '0;
            norm_min <= '0;
            dec_word <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            batch    <= '0;
            wcnt     <= '0;
            for (int s = 0; s < NUM_STATES; s++) begin
                met[0][s] <= (s == 0) ? '0 : W'(INIT_MET);
                met[1][s] <= '0;
            end
        end else begin
            if (state == IDLE) begin
                if (restart) begin
                    offset <= '0;
                    for (int s = 0; s < NUM_STATES; s++) begin
                        met[active][s] <= (s == 0) ? '0 : W'(INIT_MET);
                    end
                end else if (sym_valid) begin
                    y0_q  <= sym_y0;
                    y1_q  <= sym_y1;
                    batch <= '0;
                    wcnt  <= '0;
                end
            end

            if (state == ISSUE) batch <= batch + CNT_W'(1);

            if (beat) begin
                for (int i = 0; i < NUM_ACS; i++) begin
                    met[inactive][6'(int'(wcnt) * NUM_ACS + i)] <= acs_sm_out[i*W +: W];
                    dec_word[6'(int'(wcnt) * NUM_ACS + i)]      <= acs_prev_state[i*6 + 5];
                end
                wcnt    <= wcnt + CNT_W'(1);
                run_min <= new_min;
                if (last_beat) begin
                    active   <= inactive;
                    offset   <= new_min;
                    norm_min <= new_min;
                end
            end
        end
    end

endmodule

// File: tb/tb_viterbi_acs_scheduler.sv
// Self-checking bench: behavioural ACS bank, full-trellis reference model and a
// scoreboard of expected decision words / minima.
module tb_viterbi_acs_scheduler;

    localparam int N  = 8;
    localparam int W  = 20;
    localparam int SW = 8;
    localparam int CW = N * W;

    typedef logic [CW-1:0] cv_t;
    typedef struct {
        logic [63:0] dw;
        int          nm;
    } exp_t;

    logic            clk = 1'b0;
    logic            sys_rst;
    logic            sym_valid;
    logic            sym_ready;
    logic [SW-1:0]   sym_y0, sym_y1;
    logic            restart;
    logic            acs_valid;
    logic [CW-1:0]   acs_sm0, acs_sm1, acs_bm0, acs_bm1;
    logic            acs_valid_out;
    logic [CW-1:0]   acs_sm_out;
    logic [N*6-1:0]  acs_prev_state;
    logic            dec_valid;
    logic            dec_ready;
    logic [63:0]     dec_word;
    logic [W-1:0]    norm_min;

    viterbi_acs_scheduler #(
        .NUM_ACS(N), .STATE_MET_WIDTH(W), .SOFT_WIDTH(SW), .ACS_LATENCY(1), .INIT_MET(1024)
    ) dut (
        .clk(clk), .sys_rst(sys_rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_y0(sym_y0), .sym_y1(sym_y1), .restart(restart),
        .acs_valid(acs_valid), .acs_sm0(acs_sm0), .acs_sm1(acs_sm1),
        .acs_bm0(acs_bm0), .acs_bm1(acs_bm1),
        .acs_valid_out(acs_valid_out), .acs_sm_out(acs_sm_out), .acs_prev_state(acs_prev_state),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_word(dec_word), .norm_min(norm_min)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input cv_t got, input cv_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural ACS bank, one cycle latency ----------------
    int             bk = 0;
    logic [CW-1:0]  acs_sm_nx;
    logic [N*6-1:0] acs_prev_nx;

    always_comb begin
        logic [W-1:0] m0, m1;
        logic [5:0]   s;
        m0          = '0;
        m1          = '0;
        s           = '0;
        acs_sm_nx   = '0;
        acs_prev_nx = '0;
        for (int i = 0; i < N; i++) begin
            s  = 6'(bk * N + i);
            m0 = acs_sm0[i*W +: W] + acs_bm0[i*W +: W];
            m1 = acs_sm1[i*W +: W] + acs_bm1[i*W +: W];
            if (m1 < m0) begin
                acs_sm_nx[i*W +: W] = m1;
                acs_prev_nx[i*6 +: 6] = {1'b1, s[5:1]};
            end else begin
                acs_sm_nx[i*W +: W] = m0;
                acs_prev_nx[i*6 +: 6] = {1'b0, s[5:1]};
            end
        end
    end

    always @(posedge clk) begin
        if (sys_rst) begin
            acs_valid_out  <= 1'b0;
            acs_sm_out     <= '0;
            acs_prev_state <= '0;
            bk             <= 0;
        end else begin
            acs_valid_out <= acs_valid;
            if (acs_valid) begin
                acs_sm_out     <= acs_sm_nx;
                acs_prev_state <= acs_prev_nx;
                bk             <= (bk + 1) % (64 / N);
            end
        end
    end

    // ---------------- reference trellis model ----------------
    int ref_met[64];
    int ref_off;
    int pre_met[64];
    int pre_off, pre_y0, pre_y1;
    exp_t sb[$];
    int acc_n = 0, pop_n = 0;
    int b0_sm0 = -1, b0_sm1 = -1;

    function automatic int bm_of(input int p, input int b, input int y0, input int y1);
        logic [6:0] r;
        logic       e0, e1;
        r  = 7'((b << 6) | p);
        e0 = ^(r & 7'o171);
        e1 = ^(r & 7'o133);
        return (e0 ? 255 - y0 : y0) + (e1 ? 255 - y1 : y1);
    endfunction

    task automatic model_init();
        for (int s = 0; s < 64; s++) ref_met[s] = (s == 0) ? 0 : 1024;
        ref_off = 0;
    endtask

    task automatic model_step(input int y0, input int y1, output exp_t e);
        int nw[64];
        int p0, p1, b, m0, m1, mn;
        mn = 32'h7fff_ffff;
        e.dw = '0;
        for (int s = 0; s < 64; s++) begin
            p0 = s >> 1;
            p1 = 32 + (s >> 1);
            b  = s & 1;
            m0 = ref_met[p0] - ref_off + bm_of(p0, b, y0, y1);
            m1 = ref_met[p1] - ref_off + bm_of(p1, b, y0, y1);
            if (m1 < m0) begin e.dw[s] = 1'b1; nw[s] = m1; end
            else         begin e.dw[s] = 1'b0; nw[s] = m0; end
            if (nw[s] < mn) mn = nw[s];
        end
        for (int s = 0; s < 64; s++) ref_met[s] = nw[s];
        ref_off = mn;
        e.nm    = mn;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   acc_cyc, acs_cnt, iss_min, iss_max, s, p0, p1, b, v;
        logic dv_prev;
        cv_t  e_sm0, e_sm1, e_bm0, e_bm1;
        exp_t e;
        acc_cyc = 0; acs_cnt = 0; iss_min = 0; iss_max = 0; dv_prev = 1'b0;
        model_init();
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                model_init();
                sb.delete();
                acs_cnt = 0;
                dv_prev = 1'b0;
            end else begin
                if (restart) model_init();
                if (sym_valid && sym_ready) begin
                    for (int k = 0; k < 64; k++) pre_met[k] = ref_met[k];
                    pre_off = ref_off;
                    pre_y0  = int'(sym_y0);
                    pre_y1  = int'(sym_y1);
                    model_step(pre_y0, pre_y1, e);
                    sb.push_back(e);
                    acc_cyc = cyc;
                    acs_cnt = 0;
                    iss_min = 32'h7fff_ffff;
                    iss_max = 0;
                    acc_n++;
                end
                if (acs_valid) begin
                    for (int i = 0; i < N; i++) begin
                        s  = acs_cnt * N + i;
                        p0 = s >> 1;
                        p1 = 32 + (s >> 1);
                        b  = s & 1;
                        e_sm0[i*W +: W] = W'(pre_met[p0] - pre_off);
                        e_sm1[i*W +: W] = W'(pre_met[p1] - pre_off);
                        e_bm0[i*W +: W] = W'(bm_of(p0, b, pre_y0, pre_y1));
                        e_bm1[i*W +: W] = W'(bm_of(p1, b, pre_y0, pre_y1));
                        v = int'(acs_sm0[i*W +: W]);
                        if (v < iss_min) iss_min = v;
                        if (v > iss_max) iss_max = v;
                        v = int'(acs_sm1[i*W +: W]);
                        if (v < iss_min) iss_min = v;
                        if (v > iss_max) iss_max = v;
                    end
                    check("issue_sm0", acs_sm0, e_sm0);
                    check("issue_sm1", acs_sm1, e_sm1);
                    check("issue_bm0", acs_bm0, e_bm0);
                    check("issue_bm1", acs_bm1, e_bm1);
                    if (acs_cnt == 0) begin
                        b0_sm0 = int'(acs_sm0[W-1:0]);
                        b0_sm1 = int'(acs_sm1[W-1:0]);
                    end
                    acs_cnt++;
                end
                if (dec_valid && !dv_prev) begin
                    check("dec_latency", cv_t'(cyc - acc_cyc), cv_t'(10));
                    check("batch_count", cv_t'(acs_cnt), cv_t'(64 / N));
                    check("issued_min", cv_t'(iss_min), cv_t'(0));
                    check("issued_max_bound", cv_t'(iss_max < 8192), cv_t'(1));
                end
                if (dec_valid && dec_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_word", cv_t'(1), cv_t'(0));
                    end else begin
                        e = sb.pop_front();
                        check("dec_word", cv_t'(dec_word), cv_t'(e.dw));
                        check("norm_min", cv_t'(norm_min), cv_t'(e.nm));
                    end
                    pop_n++;
                end
                dv_prev = dec_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int a, input int b);
        int n;
        @(posedge clk); #1;
        sym_valid = 1'b1;
        sym_y0    = SW'(a);
        sym_y1    = SW'(b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_ready && n < 100);
        if (!sym_ready) check("send_timeout", cv_t'(sym_ready), cv_t'(1));
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic wait_dec();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dec_valid && n < 200);
        if (!dec_valid) check("dec_timeout", cv_t'(dec_valid), cv_t'(1));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_sym_ready"}, cv_t'(sym_ready), cv_t'(1));
        check({tag, "_dec_valid"}, cv_t'(dec_valid), cv_t'(0));
        check({tag, "_acs_valid"}, cv_t'(acs_valid), cv_t'(0));
        check({tag, "_norm_min"}, cv_t'(norm_min), cv_t'(0));
        check({tag, "_dec_word"}, cv_t'(dec_word), cv_t'(0));
    endtask

    initial begin
        int a0, p0n;
        sys_rst = 1'b1; sym_valid = 1'b0; sym_y0 = '0; sym_y1 = '0;
        restart = 1'b0; dec_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b0;
        @(negedge clk);
        reset_checks("reset");

        // (0,0) from reset: state 0 takes the zero-cost branch
        send(0, 0);
        wait_dec();
        check("b0_sm0_reset", cv_t'(b0_sm0), cv_t'(0));
        check("b0_sm1_reset", cv_t'(b0_sm1), cv_t'(1024));
        check("zero_pair_dec0", cv_t'(dec_word[0]), cv_t'(0));
        check("zero_pair_norm", cv_t'(norm_min), cv_t'(0));
        @(negedge clk);
        check("dec_valid_one_cycle", cv_t'(dec_valid), cv_t'(0));

        // traceback backpressure
        dec_ready = 1'b0;
        send(40, 200);
        wait_dec();
        for (int i = 0; i < 5; i++) begin
            check("stall_dec_valid", cv_t'(dec_valid), cv_t'(1));
            if (sb.size() > 0) check("stall_dec_word", cv_t'(dec_word), cv_t'(sb[0].dw));
            check("stall_sym_ready", cv_t'(sym_ready), cv_t'(0));
            check("stall_acs_valid", cv_t'(acs_valid), cv_t'(0));
            @(negedge clk);
        end
        @(posedge clk); #1 dec_ready = 1'b1;
        @(negedge clk);
        check("release_sym_ready_same", cv_t'(sym_ready), cv_t'(0));
        @(negedge clk);
        check("release_sym_ready_next", cv_t'(sym_ready), cv_t'(1));

        // normalisation under a long run of strong-one pairs
        for (int i = 0; i < 20; i++) begin
            send(255, 255);
            wait_dec();
        end

        // restart after three symbols
        for (int i = 0; i < 3; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255));
            wait_dec();
        end
        @(negedge clk);
        check("pre_restart_ready", cv_t'(sym_ready), cv_t'(1));
        @(posedge clk); #1 restart = 1'b1; sym_valid = 1'b1; sym_y0 = 8'd7; sym_y1 = 8'd9;
        @(negedge clk);
        check("restart_sym_ready", cv_t'(sym_ready), cv_t'(0));
        @(posedge clk); #1 restart = 1'b0; sym_valid = 1'b0;
        @(negedge clk);
        check("post_restart_ready", cv_t'(sym_ready), cv_t'(1));
        send(17, 99);
        wait_dec();
        check("b0_sm0_restart", cv_t'(b0_sm0), cv_t'(0));
        check("b0_sm1_restart", cv_t'(b0_sm1), cv_t'(1024));

        // reset in the middle of a symbol
        send(100, 30);
        repeat (3) @(posedge clk);
        #1 sys_rst = 1'b1;
        @(posedge clk); #1 sys_rst = 1'b0;
        @(negedge clk);
        reset_checks("midrst");
        send(5, 250);
        wait_dec();
        check("b0_sm0_midrst", cv_t'(b0_sm0), cv_t'(0));
        check("b0_sm1_midrst", cv_t'(b0_sm1), cv_t'(1024));

        // sym_valid held with data changing every cycle
        @(negedge clk);
        a0  = acc_n;
        p0n = pop_n;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            sym_valid = 1'b1;
            sym_y0    = SW'($urandom_range(0, 255));
            sym_y1    = SW'($urandom_range(0, 255));
        end
        @(posedge clk); #1 sym_valid = 1'b0;
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        check("held_accepts_nonzero", cv_t'(acc_n - a0 >= 4), cv_t'(1));
        check("held_one_word_per_accept", cv_t'(pop_n - p0n), cv_t'(acc_n - a0));
        check("scoreboard_drained", cv_t'(sb.size()), cv_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog got=%0d exp=below_50000_cycles", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_acs_scheduler.md
Name: viterbi_acs_scheduler

Overview:
- Sequences a bank of NUM_ACS external acs_butterfly units across all 64 trellis states for each received soft symbol pair in the LRPT Viterbi decoder. The code is K=7, rate 1/2, with G1=171o and G2=133o.
- Owns a ping-pong state-metric store, generates branch metrics, and issues batches to the ACS bank.
- Collects the new metrics and decisions, applies per-symbol normalisation, and hands a 64-bit decision word to traceback.
- Sits between the soft-symbol deinterleaver/depuncture stage and the traceback unit.

Parameters:
NUM_ACS, 8, butterflies per batch; must divide 64; 64/NUM_ACS batches per symbol
STATE_MET_WIDTH, 20, state-metric width; matches the ACS bank
SOFT_WIDTH, 8, unsigned soft-bit width; 0 = strong '0', all-ones = strong '1'
ACS_LATENCY, 1, cycles from acs_valid to acs_valid_out
INIT_MET, 1024, reset/restart metric for every state except state 0

Ports:
clk  in  1  system clock
sys_rst  in  1  synchronous active-high reset
sym_valid  in  1  soft pair valid
sym_ready  out  1  scheduler can accept a pair
sym_y0  in  SOFT_WIDTH  soft bit for G1
sym_y1  in  SOFT_WIDTH  soft bit for G2
restart  in  1  reinitialise metrics; sampled only in IDLE
acs_valid  out  1  batch issue strobe to the ACS bank
acs_sm0  out  NUM_ACS*STATE_MET_WIDTH  predecessor-0 metrics, unit i at slice i
acs_sm1  out  NUM_ACS*STATE_MET_WIDTH  predecessor-1 metrics
acs_bm0  out  NUM_ACS*STATE_MET_WIDTH  branch metric via predecessor 0
acs_bm1  out  NUM_ACS*STATE_MET_WIDTH  branch metric via predecessor 1
acs_valid_out  in  1  result strobe from unit 0 (all units in lockstep)
acs_sm_out  in  NUM_ACS*STATE_MET_WIDTH  new metrics
acs_prev_state  in  NUM_ACS*6  selected predecessor per unit
dec_valid  out  1  decision word valid
dec_ready  in  1  traceback accepts the word
dec_word  out  64  bit s = 1 if state s chose predecessor 1
norm_min  out  STATE_MET_WIDTH  minimum subtracted during the last symbol

Behaviour:
Reset values:
- FSM goes to IDLE.
- Outputs: sym_ready=1, acs_valid=0, dec_valid=0, dec_word=0, norm_min=0, all acs_* data = 0.
- Bank 0 is active: state 0 = 0, all other states = INIT_MET.
- Bank 1 = 0. The pending normalisation offset = 0.

Trellis:
- Next state s = {prev[4:0], b}.
- Predecessors: p0 = {1'b0, s[5:1]}, p1 = {1'b1, s[5:1]}. The input bit is b = s[0].
- Expected output pair: e0 = parity(G1 & {b, p}), e1 = parity(G2 & {b, p}), with b at bit 6.

Branch metric:
- bm = (e0 ? MAX - y0 : y0) + (e1 ? MAX - y1 : y1), where MAX = 2^SOFT_WIDTH - 1.
- Result is SOFT_WIDTH+1 bits, zero-extended to STATE_MET_WIDTH.

FSM:
- IDLE
  - If restart=1: reinitialise the active bank as at reset, clear the offset, stay in IDLE for 1 cycle with sym_ready=0. restart takes priority over sym_valid.
  - Else if sym_valid & sym_ready: latch y0/y1 and go to ISSUE.
- ISSUE
  - One batch per cycle, batch k = 0 .. 64/NUM_ACS-1, acs_valid=1.
  - Unit i handles state s = k*NUM_ACS + i.
  - sm0/sm1 = active[p0/p1] - offset. No underflow is possible, because offset is the previous minimum.
  - After the last batch, go to DRAIN.
- DRAIN
  - Each acs_valid_out beat writes the inactive bank at states wcnt*NUM_ACS + i, then increments wcnt.
  - dec_word[s] = acs_prev_state[i][5].
  - Track the running minimum of the written metrics.
  - Results may arrive while still in ISSUE; capture them identically.
  - After the final beat: swap banks, offset <= running minimum, norm_min <= running minimum, go to DONE.
- DONE
  - dec_valid=1 and dec_word held stable.
  - On dec_ready: go to IDLE with sym_ready=1 in the next cycle.
  - dec_ready low stalls indefinitely.

Latency and throughput:
- Accept at cycle T. Batches issue at T+1 .. T+8.
- With ACS_LATENCY=1, the last result arrives at T+9 and dec_valid rises at T+10.
- With dec_ready=1, the next pair can be accepted at T+11.

Other rules:
- sym_ready is 1 only in IDLE, never during restart. sym_valid outside IDLE is ignored; the source holds it.
- An acs_valid_out beat outside ISSUE/DRAIN is ignored.
- Reset mid-symbol aborts: partial bank writes are discarded and the reset values apply next cycle.

Decomposition:
- Package viterbi_pkg:
  - K=7, NUM_STATES=64, G1=7'b1111001, G2=7'b1011011
  - fsm state enum sched_state_t {IDLE, ISSUE, DRAIN, DONE}
  - function expected_bits(prev, b) returning {e0, e1}
- Sub-module viterbi_bm_unit: combinational; takes y0, y1 and produces the four branch metrics bm00/bm01/bm10/bm11. The scheduler selects among them per state.

Test Plan:
- Reset: sys_rst for 2 cycles -> sym_ready=1, dec_valid=0, norm_min=0; first batch sm0 slice 0 = 0 and sm1 slice 0 = 1024.
- Pair (0,0) after reset, dec_ready=1:
  - State 0 bm0 = 0, so dec_word[0]=0.
  - norm_min=0, dec_valid exactly at accept+10, one cycle.
- Backpressure: dec_ready=0 for 5 cycles in DONE -> dec_valid and dec_word held, sym_ready=0, no acs_valid; accept resumes 1 cycle after dec_ready=1.
- Normalisation with 20 consecutive pairs (255,255):
  - Every norm_min equals the minimum of the metrics written that symbol.
  - The next symbol's issued sm0/sm1 minimum equals 0.
  - No metric exceeds 2^STATE_MET_WIDTH - 1.
- Restart after 3 symbols -> one cycle sym_ready=0; next symbol's batch 0 shows sm0=0, sm1=1024; offset is 0.
- sym_valid held high through ISSUE/DRAIN/DONE with changing data -> only the value present on accept cycles is consumed; exactly one dec_word per accept.
